fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front end that sits between the PC/branch logic and the decode stage. It owns the fetch address, issues in-order word reads to instruction memory, and reserves a queue slot for every request. It returns `{pc, instruction}` pairs to decode over a valid/ready handshake and discards stale responses after a redirect. It is the consumer side of the PC interface: word-addressed, incrementing by 1, reset address 0.

## Interface
- `DEPTH`, 4: queue entries; power of 2, ≥2.
- `XLEN`, 32: address and instruction width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `redirect` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in XLEN: new word address.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out XLEN: word address of request.
- `imem_rsp_valid` in 1: response beat; in order, ≥1 cycle after its request, no backpressure.
- `imem_rsp_data` in XLEN: instruction word.
- `inst_valid` out 1: decode-side valid.
- `inst_ready` in 1: decode accepts.
- `inst_data` out XLEN: instruction.
- `inst_pc` out XLEN: word address of `inst_data`.

## Operation
- Queue entry = {addr, data, filled}. Three pointers: `alloc_ptr` (request), `fill_ptr` (response), `rd_ptr` (decode). Counters: `used` (allocated, not popped; 0..DEPTH) and `drop_cnt` (stale in-flight; 0..DEPTH).
- Request: `imem_req_valid = !redirect && (used + drop_cnt < DEPTH)`, evaluated on current-cycle state with no pop bypass. `imem_req_addr = fetch_addr`.
- On request handshake: write addr into entry[alloc_ptr], clear filled, advance alloc_ptr, increment `fetch_addr` by 1. `fetch_addr` wraps from 0xFFFFFFFF to 0.
- Response: if `drop_cnt > 0`, discard the beat and decrement `drop_cnt`. Otherwise write data into entry[fill_ptr], set filled, and advance fill_ptr.
- Output: `inst_valid = !redirect && used > 0 && entry[rd_ptr].filled`. `inst_data`/`inst_pc` come from entry[rd_ptr]. The handshake pops the entry and advances rd_ptr.
- Redirect has priority over all other activity in the same cycle:
  - `fetch_addr <= redirect_pc`.
  - All pointers and `used` go to 0.
  - `drop_cnt <= drop_cnt + pending - imem_rsp_valid`, where pending = allocated-but-unfilled entries. The same-cycle response is always discarded.
  - No request and no pop occur in that cycle.
- Back-to-back redirects accumulate `drop_cnt`. The bound `used + drop_cnt ≤ DEPTH` always holds.
- Reset (async assert): `fetch_addr = 0`, pointers/`used`/`drop_cnt` = 0, all filled bits = 0. Outputs: `imem_req_valid` 0 while in reset, `imem_req_addr` 0, `inst_valid` 0, `inst_data` 0, `inst_pc` 0.
- Reset asserted mid-operation drops all state; responses arriving after reset release are a system error and are not tracked.

## Timing
- `imem_req_valid`/`imem_req_addr` depend only on registers and `redirect`, never on `imem_req_ready`.
- `inst_valid` depends only on registers and `redirect`, never on `inst_ready`.
- Fill-to-decode latency is 1 cycle: a response at T gives `inst_valid` at T+1 if that entry is at the head. Request at T with memory latency L gives `inst_valid` at T+L+1.
- Throughput: 1 request and 1 instruction per cycle sustained when memory latency + 1 < DEPTH.
- First request after reset release: cycle 0 of release, addr 0.
- Redirect at T: T+1 shows `imem_req_addr = redirect_pc` with `imem_req_valid` = 1 if `drop_cnt < DEPTH`. The earliest redirected instruction appears at T+1+L+1.
- Full (`used == DEPTH`): request held low. A pop in the same cycle does not enable a request until the next cycle.
- Empty or head unfilled: `inst_valid` = 0. Pop and fill of different entries in the same cycle are both honoured.

## Test plan
- Reset release, memory latency 1, `imem_req_ready`=1, `inst_ready`=1 → requests addr 0,1,2,…; decode sees pc 0,1,2,… with matching data; one instruction per cycle from cycle 2.
- `inst_ready`=0, DEPTH=4 → exactly 4 requests (addr 0–3), then `imem_req_valid`=0. Raising `inst_ready` drains pc 0–3 in order; the next request (addr 4) comes one cycle after the first pop.
- Latency 3 with 2 requests in flight, redirect to 0x100 → the 2 old responses are discarded, `drop_cnt` goes 2→0, and decode sees only pc 0x100, 0x101, …
- Redirect in the same cycle as a response, then a second redirect 1 cycle later → no stale instruction reaches decode; `drop_cnt` never exceeds DEPTH.
- `fetch_addr` = 0xFFFFFFFE, continuous fetch → requests 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 with matching `inst_pc`.
- Async reset asserted mid-stream (not clock-aligned) → `inst_valid`/`imem_req_valid` drop immediately; after release, fetch restarts at addr 0 with an empty queue.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues in-order word fetches, queues
// {pc, instruction} pairs for decode and drops stale beats after a redirect.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   occ_t;

    logic [XLEN-1:0] ent_addr [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_filled;

    ptr_t alloc_ptr;
    ptr_t fill_ptr;
    ptr_t rd_ptr;
    cnt_t used;
    cnt_t pend;
    cnt_t drop_cnt;
    logic [XLEN-1:0] fetch_addr;

    logic req_fire;
    logic pop;
    logic rsp_fill;
    logic rsp_drop;
    occ_t occ;
    cnt_t drop_redir;

    assign occ = occ_t'(used) + occ_t'(drop_cnt);

    // Gated by reset so nothing is requested while the block is held in reset.
    assign imem_req_valid = reset && !redirect && (occ < occ_t'(DEPTH));
    assign imem_req_addr  = fetch_addr;

    assign inst_valid = !redirect && (used != '0) && ent_filled[rd_ptr];
    assign inst_data  = ent_data[rd_ptr];
    assign inst_pc    = ent_addr[rd_ptr];

    assign req_fire = imem_req_valid && imem_req_ready;
    assign pop      = inst_valid && inst_ready;
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && !redirect;

    // Every in-flight beat becomes stale; one already arriving this cycle is consumed.
    assign drop_redir = cnt_t'(occ_t'(drop_cnt) + occ_t'(pend)
                               - occ_t'(imem_rsp_valid));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_addr <= '0;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            used       <= '0;
            pend       <= '0;
            drop_cnt   <= '0;
            ent_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else if (redirect) begin
            fetch_addr <= redirect_pc;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            used       <= '0;
            pend       <= '0;
            drop_cnt   <= drop_redir;
        end else begin
            if (req_fire) begin
                ent_addr[alloc_ptr]   <= fetch_addr;
                ent_filled[alloc_ptr] <= 1'b0;
                alloc_ptr             <= alloc_ptr + ptr_t'(1);
                fetch_addr            <= fetch_addr + XLEN'(1);
            end
            if (rsp_fill) begin
                ent_data[fill_ptr]   <= imem_rsp_data;
                ent_filled[fill_ptr] <= 1'b1;
                fill_ptr             <= fill_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - cnt_t'(1);
            end
            used <= used + cnt_t'(req_fire) - cnt_t'(pop);
            pend <= pend + cnt_t'(req_fire) - cnt_t'(rsp_fill);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a transaction-level model
// of the live instruction stream and the in-flight memory requests.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            redirect = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [XLEN-1:0] imem_rsp_data = '0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned seq;
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } mreq_t;

    typedef struct {
        int unsigned seq;
        logic [31:0] addr;
        bit          filled;
    } slot_t;

    mreq_t mem_q[$];
    slot_t live_q[$];

    logic [31:0] m_fetch = '0;
    int unsigned seq_n = 0;
    int unsigned cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    int pct_redir = 0;
    int pct_rrdy = 100;
    int pct_irdy = 100;
    int lat_min = 1;
    int lat_max = 1;

    bit          force_redir = 1'b0;
    logic [31:0] force_pc = '0;
    bit          exp_rv;
    bit          exp_iv;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    task automatic cfg(input int r, input int qr, input int ir,
                       input int lmin, input int lmax);
        pct_redir = r;
        pct_rrdy  = qr;
        pct_irdy  = ir;
        lat_min   = lmin;
        lat_max   = lmax;
    endtask

    task automatic force_to(input logic [31:0] pc);
        force_redir = 1'b1;
        force_pc    = pc;
    endtask

    task automatic step();
        mreq_t m;
        bit rf;
        bit pp;
        int unsigned lat;
        if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_pc;
            force_redir = 1'b0;
        end else begin
            redirect    = ($urandom_range(99) < pct_redir);
            redirect_pc = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < pct_rrdy);
        inst_ready     = ($urandom_range(99) < pct_irdy);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        exp_rv = !redirect && (live_q.size() + stale_cnt() < DEPTH);
        exp_iv = !redirect && live_q.size() > 0 && live_q[0].filled;

        @(negedge clk);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch);
        check("inst_valid", 32'(inst_valid), 32'(exp_iv));
        if (exp_iv) begin
            check("inst_pc", inst_pc, live_q[0].addr);
            check("inst_data", inst_data, mem_word(live_q[0].addr));
        end

        @(posedge clk);
        rf = exp_rv && imem_req_ready;
        pp = exp_iv && inst_ready;
        if (imem_rsp_valid) begin
            m = mem_q.pop_front();
            if (!redirect && !m.stale)
                foreach (live_q[i])
                    if (live_q[i].seq == m.seq) live_q[i].filled = 1'b1;
        end
        if (redirect) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            live_q.delete();
            m_fetch = redirect_pc;
        end else begin
            if (pp) void'(live_q.pop_front());
            if (rf) begin
                lat = $urandom_range(lat_max, lat_min);
                mem_q.push_back('{seq_n, m_fetch, cyc + lat, 1'b0});
                live_q.push_back('{seq_n, m_fetch, 1'b0});
                seq_n++;
                m_fetch = m_fetch + 32'd1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic check_in_reset(input string pfx);
        check({pfx, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({pfx, "_req_addr"}, imem_req_addr, 32'd0);
        check({pfx, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({pfx, "_inst_data"}, inst_data, 32'd0);
        check({pfx, "_inst_pc"}, inst_pc, 32'd0);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        check_in_reset("midrst");
        mem_q.delete();
        live_q.delete();
        m_fetch = '0;
        redirect = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #2;
        check_in_reset("rst");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        cfg(0, 100, 100, 1, 1);
        repeat (20) step();

        cfg(0, 100, 0, 1, 1);
        repeat (10) step();
        cfg(0, 100, 100, 1, 1);
        repeat (10) step();

        cfg(0, 100, 100, 3, 3);
        force_to(32'h0);
        step();
        repeat (2) step();
        force_to(32'h100);
        repeat (15) step();

        cfg(0, 100, 100, 1, 1);
        repeat (3) step();
        force_to(32'h200);
        step();
        force_to(32'h300);
        repeat (10) step();

        force_to(32'hFFFF_FFFE);
        repeat (10) step();

        cfg(8, 80, 70, 1, 4);
        repeat (1500) step();

        async_reset();
        cfg(0, 100, 100, 1, 1);
        repeat (10) step();

        cfg(8, 70, 60, 1, 5);
        repeat (800) step();
        async_reset();
        cfg(10, 85, 80, 1, 3);
        repeat (500) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
